// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with a one-stage registered RGB/sync output and a frame tick.
// Optional macro TEST_PATTERN_EN replaces upstream RGB with eight vertical colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       CLK25M,
    input  logic       Reset,
    output logic [9:0] Hcount,
    output logic [8:0] Vcount,
    output logic       Active,
    output logic       FrameTick,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       Hsync,
    output logic       Vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = 1'(SYNC_POL);
    localparam logic       SYNC_OFF = ~SYNC_ON;

    logic [9:0] hcnt_r;
    logic [9:0] vcnt_r;
    logic       active_s;
    logic       hsync_win_s;
    logic       vsync_win_s;
    logic       frame_end_s;
    logic [3:0] pix_red_s;
    logic [3:0] pix_green_s;
    logic [3:0] pix_blue_s;

`ifdef TEST_PATTERN_EN
    logic [2:0] bar_rgb_s;
    logic       unused_rgb_s;

    // Bar colour as {R,G,B} on/off for the 80-pixel bar containing column h.
    function automatic logic [2:0] bar_rgb(input logic [9:0] h);
        logic [2:0] bar;
        if (h < 10'd80)       bar = 3'd0;
        else if (h < 10'd160) bar = 3'd1;
        else if (h < 10'd240) bar = 3'd2;
        else if (h < 10'd320) bar = 3'd3;
        else if (h < 10'd400) bar = 3'd4;
        else if (h < 10'd480) bar = 3'd5;
        else if (h < 10'd560) bar = 3'd6;
        else                  bar = 3'd7;
        case (bar)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign unused_rgb_s = ^{Red_in, Green_in, Blue_in};

    // Colour bars replace the upstream pixel source.
    always_comb begin
        bar_rgb_s   = bar_rgb(hcnt_r);
        pix_red_s   = {4{bar_rgb_s[2]}};
        pix_green_s = {4{bar_rgb_s[1]}};
        pix_blue_s  = {4{bar_rgb_s[0]}};
    end
`else
    logic unused_rgb_s;

    assign unused_rgb_s = ^{Red_in[3:0], Green_in[3:0], Blue_in[3:0]};

    // Upstream colour truncated to the 4-bit DAC.
    always_comb begin
        pix_red_s   = Red_in[7:4];
        pix_green_s = Green_in[7:4];
        pix_blue_s  = Blue_in[7:4];
    end
`endif

    // Raster counters: column wraps every line, line advances on the column wrap.
    always_ff @(posedge CLK25M or posedge Reset) begin
        if (Reset) begin
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (hcnt_r == H_LAST) begin
            hcnt_r <= 10'd0;
            if (vcnt_r == V_LAST) begin
                vcnt_r <= 10'd0;
            end else begin
                vcnt_r <= vcnt_r + 10'd1;
            end
        end else begin
            hcnt_r <= hcnt_r + 10'd1;
        end
    end

    // Decodes taken on the current counts; these feed the output register.
    always_comb begin
        active_s    = (hcnt_r < H_ACT_W) && (vcnt_r < V_ACT_W);
        hsync_win_s = (hcnt_r >= HS_START) && (hcnt_r <= HS_END);
        vsync_win_s = (vcnt_r >= VS_START) && (vcnt_r <= VS_END);
        frame_end_s = (hcnt_r == H_LAST) && (vcnt_r == V_LAST);
        Hcount      = hcnt_r;
        Active      = active_s;
        if (vcnt_r < V_ACT_W) begin
            Vcount = vcnt_r[8:0];
        end else begin
            Vcount = 9'd0;
        end
    end

    // Single output stage keeps colour, syncs and the frame tick aligned.
    always_ff @(posedge CLK25M or posedge Reset) begin
        if (Reset) begin
            vgaRed    <= 4'h0;
            vgaGreen  <= 4'h0;
            vgaBlue   <= 4'h0;
            Hsync     <= SYNC_OFF;
            Vsync     <= SYNC_OFF;
            FrameTick <= 1'b0;
        end else begin
            vgaRed    <= active_s ? pix_red_s   : 4'h0;
            vgaGreen  <= active_s ? pix_green_s : 4'h0;
            vgaBlue   <= active_s ? pix_blue_s  : 4'h0;
            Hsync     <= hsync_win_s ? SYNC_ON : SYNC_OFF;
            Vsync     <= vsync_win_s ? SYNC_ON : SYNC_OFF;
            FrameTick <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: a full-size instance for line timing and a
// shrunken-geometry instance so whole frames, frame ticks and mid-frame reset fit the run.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
    } geom_t;

    typedef struct packed {
        int hcount; int vcount; int active; int ftick;
        int r; int g; int b; int hsync; int vsync;
    } exp_t;

    localparam geom_t G_FULL  = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33};
    localparam geom_t G_SMALL = '{ha:20,  hfp:3,  hs:5,  hbp:4,  va:12,  vfp:2,  vs:2, vbp:3};
    localparam int SMALL_FRAME = 32 * 19;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [7:0] red = 8'h00;
    logic [7:0] grn = 8'h00;
    logic [7:0] blu = 8'h00;

    logic [9:0] a_hc;  logic [8:0] a_vc;  logic a_act, a_ft, a_hs, a_vs;
    logic [3:0] a_r, a_g, a_b;
    logic [9:0] b_hc;  logic [8:0] b_vc;  logic b_act, b_ft, b_hs, b_vs;
    logic [3:0] b_r, b_g, b_b;

    int checks = 0;
    int errors = 0;
    int ta = 0;
    int tb = 0;
    int hs_fall = -1;
    int hs_rise = -1;
    int ticks_b = 0;
    logic prev_hs = 1'b1;
    logic force_ff = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_full (
        .CLK25M(clk), .Reset(rst_a), .Hcount(a_hc), .Vcount(a_vc), .Active(a_act),
        .FrameTick(a_ft), .Red_in(red), .Green_in(grn), .Blue_in(blu),
        .vgaRed(a_r), .vgaGreen(a_g), .vgaBlue(a_b), .Hsync(a_hs), .Vsync(a_vs)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
    ) u_small (
        .CLK25M(clk), .Reset(rst_b), .Hcount(b_hc), .Vcount(b_vc), .Active(b_act),
        .FrameTick(b_ft), .Red_in(red), .Green_in(grn), .Blue_in(blu),
        .vgaRed(b_r), .vgaGreen(b_g), .vgaBlue(b_b), .Hsync(b_hs), .Vsync(b_vs)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at time %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs t clock edges after reset release; pins reflect the raster position one edge earlier.
    function automatic exp_t model(input geom_t g, input int t,
                                   input logic [7:0] r, input logic [7:0] gi, input logic [7:0] b);
        exp_t e;
        int ht, vt, h, v, ph, pv;
        logic pa;
        logic [2:0] bars [8];
        logic [2:0] c;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        ht = g.ha + g.hfp + g.hs + g.hbp;
        vt = g.va + g.vfp + g.vs + g.vbp;
        h = t % ht;
        v = (t / ht) % vt;
        e.hcount = h;
        e.vcount = (v < g.va) ? v : 0;
        e.active = (h < g.ha && v < g.va) ? 1 : 0;
        if (t == 0) begin
            e.r = 0; e.g = 0; e.b = 0; e.hsync = 1; e.vsync = 1; e.ftick = 0;
        end else begin
            ph = (t - 1) % ht;
            pv = ((t - 1) / ht) % vt;
            pa = (ph < g.ha) && (pv < g.va);
`ifdef TEST_PATTERN_EN
            c = bars[(ph / 80 > 7) ? 7 : ph / 80];
            e.r = (pa && c[2]) ? 15 : 0;
            e.g = (pa && c[1]) ? 15 : 0;
            e.b = (pa && c[0]) ? 15 : 0;
`else
            c = 3'b000;
            e.r = pa ? int'(r) / 16 : 0;
            e.g = pa ? int'(gi) / 16 : 0;
            e.b = pa ? int'(b) / 16 : 0;
`endif
            e.hsync = (ph >= g.ha + g.hfp && ph < g.ha + g.hfp + g.hs) ? 0 : 1;
            e.vsync = (pv >= g.va + g.vfp && pv < g.va + g.vfp + g.vs) ? 0 : 1;
            e.ftick = (t % (ht * vt) == 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic check_full();
        exp_t e;
        e = model(G_FULL, ta, red, grn, blu);
        check_value("full.hcount", 32'(a_hc), e.hcount);
        check_value("full.vcount", 32'(a_vc), e.vcount);
        check_value("full.active", 32'(a_act), e.active);
        check_value("full.ftick",  32'(a_ft), e.ftick);
        check_value("full.red",    32'(a_r),  e.r);
        check_value("full.green",  32'(a_g),  e.g);
        check_value("full.blue",   32'(a_b),  e.b);
        check_value("full.hsync",  32'(a_hs), e.hsync);
        check_value("full.vsync",  32'(a_vs), e.vsync);
    endtask

    task automatic check_small();
        exp_t e;
        e = model(G_SMALL, tb, red, grn, blu);
        check_value("small.hcount", 32'(b_hc), e.hcount);
        check_value("small.vcount", 32'(b_vc), e.vcount);
        check_value("small.active", 32'(b_act), e.active);
        check_value("small.ftick",  32'(b_ft), e.ftick);
        check_value("small.red",    32'(b_r),  e.r);
        check_value("small.green",  32'(b_g),  e.g);
        check_value("small.blue",   32'(b_b),  e.b);
        check_value("small.hsync",  32'(b_hs), e.hsync);
        check_value("small.vsync",  32'(b_vs), e.vsync);
    endtask

    task automatic new_inputs();
        if (force_ff) begin
            red = 8'hFF; grn = 8'hFF; blu = 8'hFF;
        end else begin
            red = 8'($urandom); grn = 8'($urandom); blu = 8'($urandom);
        end
    endtask

    // One clock: advance model time, check both instances mid-cycle, then change inputs.
    task automatic step();
        @(posedge clk);
        if (!rst_a) ta++;
        if (!rst_b) tb++;
        @(negedge clk);
        check_full();
        check_small();
        if (!rst_a && prev_hs && !a_hs && hs_fall < 0) hs_fall = ta;
        if (!rst_a && !prev_hs && a_hs && hs_rise < 0) hs_rise = ta;
        prev_hs = a_hs;
        if (b_ft) ticks_b++;
        new_inputs();
    endtask

    initial begin
        new_inputs();
        @(negedge clk);
        check_full();
        check_small();
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            force_ff = (i >= 300 && i < 700);
            step();
        end
        force_ff = 1'b0;
        check_value("full.hsync_fall_edge", hs_fall, 657);
        check_value("full.hsync_rise_edge", hs_rise, 753);
        check_value("small.frame_ticks", ticks_b, 2500 / SMALL_FRAME);

        // Park the full instance; bring the small one to line 5, column 10 and reset it there.
        rst_a = 1'b1;
        ta = 0;
        #1;
        check_full();
        for (int i = 0; i < SMALL_FRAME && (tb % SMALL_FRAME) != 5 * 32 + 10; i++) begin
            step();
        end
        check_value("small.reset_point", tb % SMALL_FRAME, 5 * 32 + 10);
        rst_b = 1'b1;
        tb = 0;
        #1;
        check_small();
        check_value("small.async_vga_red", 32'(b_r), 0);
        step();
        rst_b = 1'b0;
        ticks_b = 0;
        for (int i = 0; i < 1300; i++) begin
            step();
            if (i == 0) check_value("small.first_hcount", 32'(b_hc), 1);
            if (i == SMALL_FRAME - 2) check_value("small.no_early_tick", ticks_b, 0);
        end
        check_value("small.ticks_after_reset", ticks_b, 1300 / SMALL_FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
